// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bundle between the MEM stage and the data-memory responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle RV32I data-memory responder with wait states and fault flagging
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);
  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        a_write;
  logic [31:0] a_addr, a_wdata;
  logic [2:0]  a_f;
  logic [1:0]  a_off;
  logic [AW-1:0] a_idx;
  logic        acc_err, exec, mem_we;
  logic [31:0] word, shifted, load_val, st_data;
  logic [3:0]  mem_be;

  // With no wait states the access executes on the acceptance edge, so it must see the live request.
  always_comb begin
    if (state_q == S_IDLE) begin
      a_write = bus.req_write;
      a_addr  = bus.req_addr;
      a_wdata = bus.req_wdata;
      a_f     = bus.req_funct3;
    end else begin
      a_write = write_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
      a_f     = funct3_q;
    end
  end

  assign a_off = a_addr[1:0];
  assign a_idx = a_addr[AW+1:2];

  always_comb begin
    logic illegal, misal, oor;
    illegal = a_write ? (a_f > 3'b010) : ((a_f[1:0] == 2'b11) || (a_f == 3'b110));
    misal   = ((a_f[1:0] == 2'b01) && a_addr[0]) || ((a_f[1:0] == 2'b10) && (a_off != 2'b00));
    oor     = {1'b0, a_addr} >= ADDR_LIMIT;
    acc_err = illegal || misal || oor;

    word    = mem[a_idx];
    shifted = word >> {a_off, 3'b000};
    st_data = a_wdata << {a_off, 3'b000};
    case (a_f[1:0])
      2'b00: begin
        load_val = a_f[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        mem_be   = 4'b0001 << a_off;
      end
      2'b01: begin
        load_val = a_f[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        mem_be   = 4'b0011 << a_off;
      end
      default: begin
        load_val = word;
        mem_be   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    exec     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          funct3_d = bus.req_funct3;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_RESP;
            exec    = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          exec    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (exec) begin
      rdata_d = (a_write || acc_err) ? 32'd0 : load_val;
      err_d   = acc_err;
    end
  end

  // The reset qualifier keeps a zero-wait request held across reset from writing the RAM.
  assign mem_we = exec && a_write && !acc_err && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      write_q  <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[a_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - bench for dmem_responder with WAIT_STATES=2 and WAIT_STATES=0 instances
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int WS [2] = '{2, 0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic        tb_req_valid [2];
  logic        tb_req_write [2];
  logic        tb_rsp_ready [2];
  logic [31:0] tb_req_addr  [2];
  logic [31:0] tb_req_wdata [2];
  logic [2:0]  tb_req_f3    [2];
  logic        o_req_ready  [2];
  logic        o_rsp_valid  [2];
  logic        o_rsp_err    [2];
  logic [31:0] o_rsp_rdata  [2];

  dmem_responder_if if0 ();
  dmem_responder_if if1 ();

  assign if0.req_valid  = tb_req_valid[0];
  assign if0.req_write  = tb_req_write[0];
  assign if0.req_addr   = tb_req_addr[0];
  assign if0.req_wdata  = tb_req_wdata[0];
  assign if0.req_funct3 = tb_req_f3[0];
  assign if0.rsp_ready  = tb_rsp_ready[0];
  assign o_req_ready[0] = if0.req_ready;
  assign o_rsp_valid[0] = if0.rsp_valid;
  assign o_rsp_rdata[0] = if0.rsp_rdata;
  assign o_rsp_err[0]   = if0.rsp_err;
  assign if1.req_valid  = tb_req_valid[1];
  assign if1.req_write  = tb_req_write[1];
  assign if1.req_addr   = tb_req_addr[1];
  assign if1.req_wdata  = tb_req_wdata[1];
  assign if1.req_funct3 = tb_req_f3[1];
  assign if1.rsp_ready  = tb_rsp_ready[1];
  assign o_req_ready[1] = if1.req_ready;
  assign o_rsp_valid[1] = if1.rsp_valid;
  assign o_rsp_rdata[1] = if1.rsp_rdata;
  assign o_rsp_err[1]   = if1.rsp_err;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_ws2 (.clk(clk), .rst_n(rst_n), .bus(if0));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (.clk(clk), .rst_n(rst_n), .bus(if1));

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  f;
    logic [31:0] rd;
    logic        err;
  } vec_t;
  vec_t vecs[$];

  logic [31:0] mm [2][DEPTH];

  function automatic void add(input logic w, input logic [31:0] a, wd, input logic [2:0] f,
                              input logic [31:0] rd, input logic err);
    vec_t v;
    v.w = w; v.a = a; v.wd = wd; v.f = f; v.rd = rd; v.err = err;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: sizes, alignment and lane offsets computed arithmetically from the access rules.
  task automatic model(input int d, input logic w, input logic [31:0] a, wd, input logic [2:0] f,
                       output logic [31:0] rd, output logic e);
    int nbytes, off, idx;
    logic legal;
    longint unsigned v, mask;
    case (f[1:0])
      2'b00: nbytes = 1;
      2'b01: nbytes = 2;
      2'b10: nbytes = 4;
      default: nbytes = 0;
    endcase
    legal = (nbytes != 0) && (w ? (f[2] == 1'b0) : !(f[2] && nbytes == 4));
    e = !legal || ({32'd0, a} >= 64'(DEPTH * 4));
    if (legal && (a % nbytes) != 0) e = 1'b1;
    rd = 32'd0;
    if (e) return;
    idx = int'(a / 4);
    off = int'(a % 4);
    if (w) begin
      for (int k = 0; k < nbytes; k++) mm[d][idx][8*(off+k) +: 8] = wd[8*k +: 8];
    end else begin
      mask = (64'd1 << (8 * nbytes)) - 1;
      v = (64'(mm[d][idx]) >> (8 * off)) & mask;
      if (!f[2] && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
      rd = v[31:0];
    end
  endtask

  task automatic issue(input int d, input logic w, input logic [31:0] a, wd, input logic [2:0] f,
                       output int lat);
    int g = 0;
    @(negedge clk);
    while (!o_req_ready[d] && g < 50) begin
      @(negedge clk);
      g++;
    end
    tb_req_valid[d] = 1'b1;
    tb_req_write[d] = w;
    tb_req_addr[d]  = a;
    tb_req_wdata[d] = wd;
    tb_req_f3[d]    = f;
    @(posedge clk);
    #1;
    tb_req_valid[d] = 1'b0;
    tb_req_write[d] = 1'($urandom());
    tb_req_addr[d]  = $urandom();
    tb_req_wdata[d] = $urandom();
    tb_req_f3[d]    = 3'($urandom());
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_rsp_valid[d] && lat < 50);
  endtask

  task automatic txn(input int d, input logic w, input logic [31:0] a, wd, input logic [2:0] f,
                     input int hold, output logic [31:0] rd, output logic e, output int lat);
    issue(d, w, a, wd, f, lat);
    repeat (hold) @(negedge clk);
    check("rsp_valid_held", 32'(o_rsp_valid[d]), 32'd1);
    rd = o_rsp_rdata[d];
    e  = o_rsp_err[d];
    tb_rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    tb_rsp_ready[d] = 1'b0;
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    check({tag, "_req_ready"}, 32'(o_req_ready[d]), 32'd1);
    check({tag, "_rsp_valid"}, 32'(o_rsp_valid[d]), 32'd0);
    check({tag, "_rsp_rdata"}, o_rsp_rdata[d], 32'd0);
    check({tag, "_rsp_err"}, 32'(o_rsp_err[d]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, erd;
    logic e, ee;
    int lat, nacc, nrv, r;
    int acc [2];
    int rv [2];
    logic sw_done;
    logic w;
    logic [31:0] a;
    logic [2:0] f;

    for (int d = 0; d < 2; d++) begin
      tb_req_valid[d] = 1'b0; tb_req_write[d] = 1'b0; tb_rsp_ready[d] = 1'b0;
      tb_req_addr[d] = 32'd0; tb_req_wdata[d] = 32'd0; tb_req_f3[d] = 3'd0;
    end

    add(1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        0);
    add(0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 0);
    add(1, 32'h11,  32'h00000080, 3'b000, 32'h0,        0);
    add(0, 32'h11,  32'h0,        3'b000, 32'hFFFFFF80, 0);
    add(0, 32'h11,  32'h0,        3'b100, 32'h00000080, 0);
    add(0, 32'h12,  32'h0,        3'b001, 32'hFFFFDEAD, 0);
    add(0, 32'h12,  32'h0,        3'b101, 32'h0000DEAD, 0);
    add(0, 32'h10,  32'h0,        3'b010, 32'hDEAD80EF, 0);
    add(1, 32'h14,  32'hCAFEF00D, 3'b010, 32'h0,        0);
    add(1, 32'h20,  32'h00000000, 3'b010, 32'h0,        0);
    add(0, 32'h12,  32'h0,        3'b010, 32'h0,        1);
    add(1, 32'h13,  32'h0000FFFF, 3'b001, 32'h0,        1);
    add(0, 32'h400, 32'h0,        3'b010, 32'h0,        1);
    add(0, 32'h10,  32'h0,        3'b011, 32'h0,        1);
    add(1, 32'h14,  32'h11111111, 3'b011, 32'h0,        1);
    add(1, 32'h400, 32'h000000AA, 3'b000, 32'h0,        1);
    add(0, 32'h14,  32'h0,        3'b010, 32'hCAFEF00D, 0);
    add(0, 32'h10,  32'h0,        3'b010, 32'hDEAD80EF, 0);
    add(1, 32'h3FC, 32'h01234567, 3'b010, 32'h0,        0);
    add(0, 32'h3FC, 32'h0,        3'b000, 32'h00000067, 0);
    add(0, 32'h3FF, 32'h0,        3'b000, 32'h00000001, 0);
    add(0, 32'h3FE, 32'h0,        3'b001, 32'h00000123, 0);

    repeat (2) @(negedge clk);
    check_reset_outputs(0, "por_ws2");
    check_reset_outputs(1, "por_ws0");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      txn(0, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].f, $urandom_range(0, 2), rd, e, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(WS[0] + 1));
    end

    // Backpressure with a competing store that must be ignored.
    issue(0, 1'b0, 32'h10, 32'h0, 3'b010, lat);
    check("bp_latency", 32'(lat), 32'd3);
    tb_req_valid[0] = 1'b1; tb_req_write[0] = 1'b1; tb_req_addr[0] = 32'h10;
    tb_req_wdata[0] = 32'h0; tb_req_f3[0] = 3'b010;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(o_rsp_valid[0]), 32'd1);
      check("bp_req_ready", 32'(o_req_ready[0]), 32'd0);
      check("bp_rdata", o_rsp_rdata[0], 32'hDEAD80EF);
      check("bp_err", 32'(o_rsp_err[0]), 32'd0);
      @(negedge clk);
    end
    tb_req_valid[0] = 1'b0;
    tb_rsp_ready[0] = 1'b1;
    @(negedge clk);
    tb_rsp_ready[0] = 1'b0;
    check("bp_release_req_ready", 32'(o_req_ready[0]), 32'd1);
    check("bp_release_rsp_valid", 32'(o_rsp_valid[0]), 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 3'b010, 0, rd, e, lat);
    check("bp_no_write", rd, 32'hDEAD80EF);

    // Zero-wait back-to-back stores with rsp_ready held high.
    tb_rsp_ready[1] = 1'b1;
    @(negedge clk);
    tb_req_valid[1] = 1'b1; tb_req_write[1] = 1'b1; tb_req_addr[1] = 32'h0;
    tb_req_wdata[1] = 32'h11111111; tb_req_f3[1] = 3'b010;
    nacc = 0; nrv = 0; sw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (o_rsp_valid[1] && nrv < 2) begin rv[nrv] = cyc; nrv++; end
      if (tb_req_valid[1] && o_req_ready[1] && nacc < 2) begin acc[nacc] = cyc; nacc++; end
      else if (nacc == 1 && !sw_done) begin
        tb_req_addr[1] = 32'h4; tb_req_wdata[1] = 32'h22222222; sw_done = 1'b1;
      end else if (nacc == 2) tb_req_valid[1] = 1'b0;
      @(negedge clk);
    end
    tb_req_valid[1] = 1'b0;
    tb_rsp_ready[1] = 1'b0;
    check("ws0_accepts", 32'(nacc), 32'd2);
    check("ws0_responses", 32'(nrv), 32'd2);
    if (nacc == 2 && nrv == 2) begin
      check("ws0_period", 32'(acc[1] - acc[0]), 32'd2);
      check("ws0_lat0", 32'(rv[0] - acc[0]), 32'd1);
      check("ws0_lat1", 32'(rv[1] - acc[1]), 32'd1);
    end
    txn(1, 1'b0, 32'h0, 32'h0, 3'b010, 1, rd, e, lat);
    check("ws0_rd0", rd, 32'h11111111);
    check("ws0_rd0_latency", 32'(lat), 32'd1);
    txn(1, 1'b0, 32'h4, 32'h0, 3'b010, 0, rd, e, lat);
    check("ws0_rd4", rd, 32'h22222222);

    // Reset during WAIT of a store: the store must vanish.
    @(negedge clk);
    tb_req_valid[0] = 1'b1; tb_req_write[0] = 1'b1; tb_req_addr[0] = 32'h20;
    tb_req_wdata[0] = 32'h12345678; tb_req_f3[0] = 3'b010;
    @(posedge clk);
    #1 tb_req_valid[0] = 1'b0;
    @(negedge clk);
    check("rstw_in_wait", 32'(o_req_ready[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0, "rstw");
    @(negedge clk);
    rst_n = 1'b1;
    txn(0, 1'b0, 32'h20, 32'h0, 3'b010, 0, rd, e, lat);
    check("rstw_rd20", rd, 32'h0);

    // Reset during RESP: a load response is dropped, a committed store survives.
    issue(0, 1'b0, 32'h10, 32'h0, 3'b010, lat);
    check("rstr_load_visible", o_rsp_rdata[0], 32'hDEAD80EF);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0, "rstr_load");
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 1'b1, 32'h24, 32'hA5A5A5A5, 3'b010, lat);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0, "rstr_store");
    @(negedge clk);
    rst_n = 1'b1;
    txn(0, 1'b0, 32'h24, 32'h0, 3'b010, 0, rd, e, lat);
    check("rstr_rd24", rd, 32'hA5A5A5A5);

    // Randomized traffic against the reference model on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 16; k++) begin
        a = 32'h100 + 32'(4 * k);
        w = 1'b1;
        f = 3'b010;
        r = int'($urandom());
        model(d, w, a, 32'(r), f, erd, ee);
        txn(d, w, a, 32'(r), f, 0, rd, e, lat);
        check($sformatf("init%0d_%0d_err", d, k), 32'(e), 32'(ee));
      end
      for (int k = 0; k < 150; k++) begin
        r = int'($urandom_range(0, 15));
        if (r == 0)      a = 32'h400 + 32'($urandom_range(0, 255));
        else if (r == 1) a = $urandom() | 32'h8000_0000;
        else             a = 32'h100 + 32'($urandom_range(0, 63));
        w = 1'($urandom_range(0, 1));
        f = 3'($urandom_range(0, 7));
        r = int'($urandom());
        model(d, w, a, 32'(r), f, erd, ee);
        txn(d, w, a, 32'(r), f, $urandom_range(0, 3), rd, e, lat);
        check($sformatf("rnd%0d_%0d_rdata", d, k), rd, erd);
        check($sformatf("rnd%0d_%0d_err", d, k), 32'(e), 32'(ee));
        check($sformatf("rnd%0d_%0d_latency", d, k), 32'(lat), 32'(WS[d] + 1));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
